// File: rtl/microcode_sequencer.sv
// microcode_sequencer: accepts one RV32I instruction per handshake, classifies it,
// selects the per-class microcode ROM and address, latches the returned microcode
// word and issues it to the datapath as L+1 micro-steps under a valid/ack handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   instr_valid/instr     instruction offer from fetch; instr_ready accepts it
//   rom_class/rom_addr    ROM select and address (class 7 = none)
//   rom_data              microcode word from the selected ROM (same cycle)
//   uop_valid/uop/uop_step/uop_ack  micro-step handshake to the datapath
//   abort                 synchronous flush back to idle
//   busy/done/illegal     status; done and illegal are one-cycle pulses
module microcode_sequencer #(
  parameter int unsigned MICROCODE_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_valid,
  input  logic [31:0]                instr,
  output logic                       instr_ready,
  output logic [2:0]                 rom_class,
  output logic [3:0]                 rom_addr,
  input  logic [MICROCODE_WIDTH-1:0] rom_data,
  output logic                       uop_valid,
  output logic [MICROCODE_WIDTH-1:0] uop,
  output logic [3:0]                 uop_step,
  input  logic                       uop_ack,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       illegal
);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StIssue,
    StDone,
    StErr
  } state_e;

  state_e                     state;
  logic [31:0]                instr_q;
  logic [MICROCODE_WIDTH-1:0] word_q;
  logic [3:0]                 step_q;

  logic [2:0] dec_class;
  logic [3:0] dec_addr;
  logic       dec_legal;

  // Classify the latched instruction; class 7 marks it illegal.
  always_comb begin
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    opcode    = instr_q[6:0];
    funct3    = instr_q[14:12];
    funct7    = instr_q[31:25];
    dec_class = 3'd7;
    dec_addr  = 4'd0;
    unique case (opcode)
      7'b0110011: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_class = 3'd0;
          dec_addr  = {instr_q[30], funct3};
        end
      end
      7'b0010011: begin
        if ((funct3 != 3'b001 || funct7 == 7'h00) &&
            (funct3 != 3'b101 || funct7 == 7'h00 || funct7 == 7'h20)) begin
          dec_class = 3'd1;
          dec_addr  = {1'b0, funct3};
        end
      end
      7'b0000011: begin
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          dec_class = 3'd2;
          dec_addr  = {1'b0, funct3};
        end
      end
      7'b0100011: begin
        if (funct3 <= 3'b010) begin
          dec_class = 3'd3;
          dec_addr  = {1'b0, funct3};
        end
      end
      7'b1100011: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          dec_class = 3'd4;
          dec_addr  = {1'b0, funct3};
        end
      end
      7'b1101111: begin
        dec_class = 3'd5;
        dec_addr  = 4'd0;
      end
      7'b1100111: begin
        if (funct3 == 3'b000) begin
          dec_class = 3'd5;
          dec_addr  = 4'd1;
        end
      end
      7'b0110111: begin
        dec_class = 3'd6;
        dec_addr  = 4'd0;
      end
      default: begin
        dec_class = 3'd7;
        dec_addr  = 4'd0;
      end
    endcase
    dec_legal = (dec_class != 3'd7);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      instr_q <= '0;
      word_q  <= '0;
      step_q  <= '0;
    end else if (abort) begin
      // Flush wins over any handshake in the same cycle.
      state  <= StIdle;
      step_q <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= StDecode;
          end
        end
        StDecode: begin
          if (dec_legal) begin
            word_q <= rom_data;
            step_q <= '0;
            state  <= StIssue;
          end else begin
            state <= StErr;
          end
        end
        StIssue: begin
          if (uop_ack) begin
            if (step_q == word_q[MICROCODE_WIDTH-1 -: 4]) begin
              state <= StDone;
            end else begin
              step_q <= step_q + 4'd1;
            end
          end
        end
        StDone:  state <= StIdle;
        StErr:   state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    instr_ready = (state == StIdle) && !abort;
    busy        = (state != StIdle);
    uop_valid   = (state == StIssue);
    uop_step    = (state == StIssue) ? step_q : 4'd0;
    uop         = (state == StIssue) ? {step_q, word_q[MICROCODE_WIDTH-5:0]} : '0;
    done        = (state == StDone) && !abort;
    illegal     = (state == StErr) && !abort;
    if (state == StDecode || state == StIssue) begin
      rom_class = dec_class;
      rom_addr  = dec_addr;
    end else begin
      rom_class = 3'd7;
      rom_addr  = 4'd0;
    end
  end

endmodule
